// File: rtl/hazard_scoreboard_pkg.sv
// hazard_scoreboard shared constants: forwarding-select encoding and the
// packed shadow-pipeline entry layout {dest, mem_r_en, wb_en, valid}.
package hazard_scoreboard_pkg;

    localparam int FWD_SEL_REG = 0;

    localparam int ENT_VALID = 0;
    localparam int ENT_WB_EN = 1;
    localparam int ENT_MEM_R = 2;
    localparam int ENT_DEST  = 3;

    function automatic int entry_width(input int addr_w);
        return addr_w + ENT_DEST;
    endfunction

endpackage

// File: rtl/hazard_stage_match.sv
// Compares one ID source register against one shadow-pipeline entry and
// reports whether the entry's result is still too young to forward.
module hazard_stage_match
    import hazard_scoreboard_pkg::*;
#(
    parameter int REG_ADDR_W = 4,
    parameter int STAGE      = 0,
    parameter int ALU_AVAIL  = 1,
    parameter int LOAD_AVAIL = 2
) (
    input  logic [REG_ADDR_W-1:0]          src,
    input  logic                           src_used,
    input  logic [REG_ADDR_W+ENT_DEST-1:0] entry,
    output logic                           match,
    output logic                           too_early
);

    localparam logic ALU_EARLY  = (STAGE + 1) < ALU_AVAIL;
    localparam logic LOAD_EARLY = (STAGE + 1) < LOAD_AVAIL;

    logic [REG_ADDR_W-1:0] dest;
    logic                  writer;

    assign dest   = entry[ENT_DEST +: REG_ADDR_W];
    // A zero destination never matches, which also makes source r0 safe.
    assign writer = entry[ENT_VALID] & entry[ENT_WB_EN] & (|dest);
    assign match  = src_used & writer & (dest == src);

    assign too_early = match &
        (entry[ENT_MEM_R] ? LOAD_EARLY : ALU_EARLY);

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard detection / forwarding control beside ID using a shadow pipeline.
// Optional HAZARD_PERF_CNT_EN adds saturating stall counters.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int REG_ADDR_W = 4,
    parameter int NUM_STAGES = 3,
    parameter int ALU_AVAIL  = 1,
    parameter int LOAD_AVAIL = 2,
    parameter int FWD_SEL_W  = $clog2(NUM_STAGES)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  forward_en,
    input  logic                  id_valid,
    input  logic                  id_kill,
    input  logic [REG_ADDR_W-1:0] id_src1,
    input  logic [REG_ADDR_W-1:0] id_src2,
    input  logic                  id_src1_used,
    input  logic                  id_src2_used,
    input  logic [REG_ADDR_W-1:0] id_dest,
    input  logic                  id_wb_en,
    input  logic                  id_mem_r_en,
    output logic                  stall,
    output logic [FWD_SEL_W-1:0]  exe_fwd_sel1,
    output logic [FWD_SEL_W-1:0]  exe_fwd_sel2,
`ifdef HAZARD_PERF_CNT_EN
    output logic [31:0]           stall_cycles,
    output logic [31:0]           load_use_stalls,
`endif
    output logic                  exe_valid
);

    localparam int EW = entry_width(REG_ADDR_W);
    localparam int NM = NUM_STAGES - 1;

    // The WB entry is never compared (regfile write-through covers it),
    // so only the stages that can be matched are stored.
    logic [EW-1:0] s [NM];

    logic [NM-1:0] m1, m2, e1, e2, ld_vec, cause;
    logic          hazard, issue;
    logic [EW-1:0] new_ent;
    logic [FWD_SEL_W-1:0] sel1_d, sel2_d;

    for (genvar j = 0; j < NM; j++) begin : g_match
        hazard_stage_match #(
            .REG_ADDR_W (REG_ADDR_W),
            .STAGE      (j),
            .ALU_AVAIL  (ALU_AVAIL),
            .LOAD_AVAIL (LOAD_AVAIL)
        ) u_m1 (
            .src       (id_src1),
            .src_used  (id_src1_used),
            .entry     (s[j]),
            .match     (m1[j]),
            .too_early (e1[j])
        );

        hazard_stage_match #(
            .REG_ADDR_W (REG_ADDR_W),
            .STAGE      (j),
            .ALU_AVAIL  (ALU_AVAIL),
            .LOAD_AVAIL (LOAD_AVAIL)
        ) u_m2 (
            .src       (id_src2),
            .src_used  (id_src2_used),
            .entry     (s[j]),
            .match     (m2[j]),
            .too_early (e2[j])
        );

        assign ld_vec[j] = s[j][ENT_MEM_R];
    end

    assign cause  = forward_en ? (e1 | e2) : (m1 | m2);
    assign hazard = |cause;
    assign stall  = hazard & id_valid & ~id_kill;
    assign issue  = id_valid & ~id_kill & ~stall;

    assign new_ent = issue ?
        {id_dest, id_mem_r_en, id_wb_en, 1'b1} : '0;

    // Descending scan so the youngest matching stage wins.
    always_comb begin
        sel1_d = FWD_SEL_W'(FWD_SEL_REG);
        sel2_d = FWD_SEL_W'(FWD_SEL_REG);
        for (int j = NM - 1; j >= 0; j--) begin
            if (m1[j]) sel1_d = FWD_SEL_W'(j + 1);
            if (m2[j]) sel2_d = FWD_SEL_W'(j + 1);
        end
        if (!(forward_en && issue)) begin
            sel1_d = FWD_SEL_W'(FWD_SEL_REG);
            sel2_d = FWD_SEL_W'(FWD_SEL_REG);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int j = 0; j < NM; j++) s[j] <= '0;
            exe_fwd_sel1 <= '0;
            exe_fwd_sel2 <= '0;
        end else begin
            s[0] <= new_ent;
            for (int j = 1; j < NM; j++) s[j] <= s[j-1];
            exe_fwd_sel1 <= sel1_d;
            exe_fwd_sel2 <= sel2_d;
        end
    end

    assign exe_valid = s[0][ENT_VALID];

`ifdef HAZARD_PERF_CNT_EN
    logic load_only;

    assign load_only = stall & ~|(cause & ~ld_vec);

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles    <= '0;
            load_use_stalls <= '0;
        end else begin
            if (stall && stall_cycles != '1)
                stall_cycles <= stall_cycles + 32'd1;
            if (load_only && load_use_stalls != '1)
                load_use_stalls <= load_use_stalls + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench for hazard_scoreboard: directed pipeline scenarios
// followed by randomized traffic against an in-flight-instruction model.
module tb_hazard_scoreboard;

    localparam int AW = 4;
    localparam int N  = 3;
    localparam int AA = 1;
    localparam int LA = 2;
    localparam int SW = $clog2(N);

    logic          clk = 1'b0;
    logic          rst;
    logic          forward_en;
    logic          id_valid;
    logic          id_kill;
    logic [AW-1:0] id_src1, id_src2, id_dest;
    logic          id_src1_used, id_src2_used;
    logic          id_wb_en, id_mem_r_en;
    logic          stall;
    logic [SW-1:0] exe_fwd_sel1, exe_fwd_sel2;
    logic          exe_valid;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0]   stall_cycles, load_use_stalls;
`endif

    hazard_scoreboard #(
        .REG_ADDR_W (AW),
        .NUM_STAGES (N),
        .ALU_AVAIL  (AA),
        .LOAD_AVAIL (LA)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .forward_en   (forward_en),
        .id_valid     (id_valid),
        .id_kill      (id_kill),
        .id_src1      (id_src1),
        .id_src2      (id_src2),
        .id_src1_used (id_src1_used),
        .id_src2_used (id_src2_used),
        .id_dest      (id_dest),
        .id_wb_en     (id_wb_en),
        .id_mem_r_en  (id_mem_r_en),
        .stall        (stall),
        .exe_fwd_sel1 (exe_fwd_sel1),
        .exe_fwd_sel2 (exe_fwd_sel2),
`ifdef HAZARD_PERF_CNT_EN
        .stall_cycles    (stall_cycles),
        .load_use_stalls (load_use_stalls),
`endif
        .exe_valid    (exe_valid)
    );

    always #5 clk = ~clk;

    // Instructions in flight, indexed by cycles since leaving ID.
    typedef struct {
        bit v;
        bit wb;
        bit ld;
        int dest;
    } ent_t;

    typedef struct {
        bit v;
        int s1;
        int s2;
    } exp_t;

    ent_t pipe [N];
    exp_t q [$];
    int   tests = 0;
    int   fails = 0;
    int   m_stalls = 0;
    int   m_ld_stalls = 0;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic void model(
        input bit fe, input int a1, input bit u1,
        input int a2, input bit u2,
        output bit hz, output int s1, output int s2, output bit lonly);
        bit other = 0;
        hz = 0; s1 = 0; s2 = 0;
        for (int k = 0; k < N - 1; k++) begin
            if (pipe[k].v && pipe[k].wb && pipe[k].dest != 0) begin
                int  avail = pipe[k].ld ? LA : AA;
                bit  blk   = fe ? (k + 1 < avail) : 1'b1;
                bit  h1    = u1 && a1 == pipe[k].dest;
                bit  h2    = u2 && a2 == pipe[k].dest;
                if (h1 && s1 == 0) s1 = k + 1;
                if (h2 && s2 == 0) s2 = k + 1;
                if ((h1 || h2) && blk) begin
                    hz = 1;
                    if (!pipe[k].ld) other = 1;
                end
            end
        end
        lonly = hz && !other;
    endfunction

    // One cycle: drive at negedge, check stall, push expectation, advance.
    task automatic step(
        input bit r, input bit v, input bit k,
        input int a1, input bit u1, input int a2, input bit u2,
        input int d, input bit wb, input bit ld, input bit fe,
        output bit st);
        bit   hz, lonly, iss;
        int   s1, s2;
        exp_t e;
        rst = r; id_valid = v; id_kill = k;
        id_src1 = AW'(a1); id_src1_used = u1;
        id_src2 = AW'(a2); id_src2_used = u2;
        id_dest = AW'(d); id_wb_en = wb; id_mem_r_en = ld;
        forward_en = fe;
        #1;
        model(fe, a1, u1, a2, u2, hz, s1, s2, lonly);
        st  = hz && v && !k;
        iss = v && !k && !st;
        if (!r) check("stall", int'(stall), int'(st));
        e.v  = !r && iss;
        e.s1 = (!r && iss && fe) ? s1 : 0;
        e.s2 = (!r && iss && fe) ? s2 : 0;
        q.push_back(e);
        @(posedge clk);
        if (r) begin
            foreach (pipe[i]) pipe[i] = '{0, 0, 0, 0};
            m_stalls = 0;
            m_ld_stalls = 0;
        end else begin
            for (int i = N - 1; i > 0; i--) pipe[i] = pipe[i-1];
            pipe[0] = iss ? '{1, wb, ld, d} : '{0, 0, 0, 0};
            if (st) m_stalls++;
            if (st && lonly) m_ld_stalls++;
        end
        @(negedge clk);
    endtask

    task automatic issue(
        input int a1, input bit u1, input int a2, input bit u2,
        input int d, input bit wb, input bit ld, input bit fe,
        output int nstall);
        bit st;
        nstall = 0;
        do begin
            step(0, 1, 0, a1, u1, a2, u2, d, wb, ld, fe, st);
            if (st) nstall++;
        end while (st && nstall < 8);
        if (st) check("issue_timeout", nstall, 0);
    endtask

    task automatic bubbles(input int n);
        bit st;
        for (int i = 0; i < n; i++)
            step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, st);
    endtask

    always begin
        exp_t e;
        @(posedge clk);
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            check("exe_valid", int'(exe_valid), int'(e.v));
            check("exe_fwd_sel1", int'(exe_fwd_sel1), e.s1);
            check("exe_fwd_sel2", int'(exe_fwd_sel2), e.s2);
        end
    end

    initial begin
        bit st;
        int ns;
        foreach (pipe[i]) pipe[i] = '{0, 0, 0, 0};
        step(1, 1, 0, 1, 1, 2, 1, 3, 1, 0, 1, st);
        step(1, 1, 0, 1, 1, 2, 1, 3, 1, 0, 1, st);
        check("reset_exe_valid", int'(exe_valid), 0);
        check("reset_sel1", int'(exe_fwd_sel1), 0);

        // ALU -> dependent ALU: forwarded from s[1], no stall
        issue(1, 1, 2, 1, 3, 1, 0, 1, ns);
        issue(3, 1, 5, 1, 4, 1, 0, 1, ns);
        check("alu_use_stalls", ns, 0);
        bubbles(3);

        // Load -> use: one stall, then both selects from s[2]
        issue(0, 0, 0, 0, 6, 1, 1, 1, ns);
        issue(6, 1, 6, 1, 7, 1, 0, 1, ns);
        check("load_use_stalls", ns, 1);
        bubbles(3);

        // Stall-only mode: wait until the producer reaches WB
        issue(1, 1, 2, 1, 3, 1, 0, 0, ns);
        issue(3, 1, 5, 1, 4, 1, 0, 0, ns);
        check("no_fwd_stalls", ns, N - 1);
        bubbles(3);

        // r0 is never a hazard
        issue(1, 1, 2, 1, 0, 1, 1, 1, ns);
        issue(0, 1, 0, 1, 5, 1, 0, 1, ns);
        check("r0_stalls", ns, 0);
        bubbles(3);

        // Kill wins over a hazard
        issue(0, 0, 0, 0, 6, 1, 1, 1, ns);
        step(0, 1, 1, 6, 1, 0, 0, 7, 1, 0, 1, st);
        check("kill_stall", int'(st), 0);
        bubbles(3);

        // Reset in the middle of a load-use stall
        issue(0, 0, 0, 0, 6, 1, 1, 1, ns);
        step(0, 1, 0, 6, 1, 0, 0, 7, 1, 0, 1, st);
        step(1, 1, 0, 6, 1, 0, 0, 7, 1, 0, 1, st);
        check("rst_exe_valid", int'(exe_valid), 0);
        step(0, 1, 0, 6, 1, 0, 0, 7, 1, 0, 1, st);
        check("post_rst_stall", int'(st), 0);
        bubbles(3);

        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 299) == 0,
                 $urandom_range(0, 3) != 0,
                 $urandom_range(0, 7) == 0,
                 $urandom_range(0, 3), $urandom_range(0, 3) != 0,
                 $urandom_range(0, 3), $urandom_range(0, 3) != 0,
                 $urandom_range(0, 3), $urandom_range(0, 3) != 0,
                 $urandom_range(0, 2) == 0,
                 $urandom_range(0, 4) != 0, st);
        end

        bubbles(N + 1);
        @(posedge clk);
        #2;
        check("queue_drain", q.size(), 0);
`ifdef HAZARD_PERF_CNT_EN
        check("stall_cycles", int'(stall_cycles), m_stalls);
        check("load_use_cnt", int'(load_use_stalls), m_ld_stalls);
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
